// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register: owns the PC, runs the imem
// request handshake, and applies redirect/stall/bubble rules to IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  PCsrc,
  input  logic [31:0] jr_target,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is imem_req=1 with imem_addr; it completes on the
  // rising edge where imem_ready=1, and req/addr hold steady until then.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic        bubble;
  logic [31:0] target;
  logic [31:0] pc_seq;

  assign redirect = valid_q && (PCsrc != 2'b00) && !stall;
  assign pc_seq   = pc_q + 32'd4;

  always_comb begin
    case (PCsrc)
      2'b01:   target = jr_target;
      2'b10:   target = branch_target;
      default: target = {pc4_q[31:28], instr_q[25:0], 2'b00};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      buf_q   <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    buf_d   = buf_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    bubble  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          bubble = 1'b1;
          if (imem_ready) begin
            pc_d = target;
          end else begin
            pend_d  = target;
            state_d = S_DRAIN;
          end
        end else if (imem_ready) begin
          if (!stall) begin
            instr_d = imem_rdata;
            pc4_d   = pc_seq;
            valid_d = 1'b1;
            pc_d    = pc_seq;
          end else begin
            buf_d   = imem_rdata;
            state_d = S_HELD;
          end
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      S_DRAIN: begin
        // The abandoned fetch must still complete before the new PC is issued.
        bubble = 1'b1;
        if (imem_ready) begin
          pc_d    = pend_q;
          state_d = S_FETCH;
        end
      end
      S_HELD: begin
        if (redirect) begin
          bubble  = 1'b1;
          pc_d    = target;
          state_d = S_FETCH;
        end else if (!stall) begin
          instr_d = buf_q;
          pc4_d   = pc_seq;
          valid_d = 1'b1;
          pc_d    = pc_seq;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
    if (bubble) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_comb begin
    imem_req    = !rst && (state_q != S_HELD);
    imem_addr   = pc_q;
    pc          = pc_q;
    if_id_instr = instr_q;
    if_id_pc4   = pc4_q;
    if_id_valid = valid_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a random run checked against
// a program-order model of which instruction ID must see next.
module tb_fetch_stage;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic [1:0]  PCsrc = 2'b00;
  logic [31:0] jr_target = '0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model state
  bit          busy = 0;
  int          wait_left = 0;
  int          mem_wait = 0;
  bit          mem_wait_rand = 0;
  logic [31:0] req_addr = '0;
  bit          mem_cont = 0;
  bit          mem_drop = 0;
  bit          ov_en = 0;
  logic [31:0] ov_addr = '0;
  logic [31:0] ov_data = '0;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .PCsrc        (PCsrc),
    .jr_target    (jr_target),
    .branch_target(branch_target),
    .pc           (pc),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ov_en && a == ov_addr) return ov_data;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic next();
    @(negedge clk);
  endtask

  // Responds to the request visible this cycle; ready asserts after the chosen wait count.
  task automatic mem_tick();
    #1;
    mem_cont = 0;
    mem_drop = 0;
    if (!imem_req) begin
      mem_drop   = busy && !rst;
      busy       = 0;
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end else begin
      if (busy) begin
        mem_cont = 1;
      end else begin
        busy      = 1;
        req_addr  = imem_addr;
        wait_left = mem_wait_rand ? int'($urandom_range(0, 3)) : mem_wait;
      end
      if (wait_left == 0) begin
        imem_ready = 1'b1;
        imem_rdata = mem_word(req_addr);
        busy       = 0;
      end else begin
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        wait_left--;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; PCsrc = 2'b00; ov_en = 0; mem_wait_rand = 0;
    mem_tick(); next();
    mem_tick(); next();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({imem_req, if_id_valid, if_id_instr, if_id_pc4, pc, dbg_state} !==
        {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, S_FETCH}) begin
      n_fail++;
      $display("FAIL reset_state got req=%b v=%b i=%h p4=%h pc=%h st=%0d exp 0/0/0/0/0/FETCH",
               imem_req, if_id_valid, if_id_instr, if_id_pc4, pc, dbg_state);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] w;
    do_reset();
    mem_wait = 0; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_tick(); next();
      w = mem_word(32'(4 * i));
      n_checks++;
      if ({if_id_valid, if_id_instr, if_id_pc4, pc, imem_req} !==
          {1'b1, w, 32'(4 * (i + 1)), 32'(4 * (i + 1)), 1'b1}) begin
        n_fail++;
        $display("FAIL zero_wait_%0d got v=%b i=%h p4=%h pc=%h exp v=1 i=%h p4/pc=%h",
                 i, if_id_valid, if_id_instr, if_id_pc4, pc, w, 32'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_wait_states();
    logic        ev;
    logic [31:0] ei, ep;
    do_reset();
    mem_wait = 2; rst = 1'b0;
    for (int j = 0; j < 9; j++) begin
      mem_tick();
      if (mem_cont) begin
        n_checks++;
        if (imem_addr !== req_addr) begin
          n_fail++;
          $display("FAIL wait_addr_stable got %h exp %h", imem_addr, req_addr);
        end
      end
      next();
      ev = (j % 3 == 2);
      ei = ev ? mem_word(32'(4 * (j / 3))) : 32'h0;
      ep = 32'(4 * ((j + 1) / 3));
      n_checks++;
      if ({if_id_valid, if_id_instr, pc} !== {ev, ei, ep}) begin
        n_fail++;
        $display("FAIL wait2_cycle%0d got v=%b i=%h pc=%h exp v=%b i=%h pc=%h",
                 j, if_id_valid, if_id_instr, pc, ev, ei, ep);
      end
    end
  endtask

  task automatic test_jr();
    do_reset();
    mem_wait = 0; rst = 1'b0;
    mem_tick(); next();
    PCsrc = 2'b01; jr_target = 32'h40;
    mem_tick(); next();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc4, pc, imem_addr} !==
        {1'b0, 32'h0, 32'h0, 32'h40, 32'h40}) begin
      n_fail++;
      $display("FAIL jr_bubble got v=%b i=%h p4=%h pc=%h addr=%h exp 0/0/0/40/40",
               if_id_valid, if_id_instr, if_id_pc4, pc, imem_addr);
    end
    PCsrc = 2'b00;
    mem_tick(); next();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc4} !== {1'b1, mem_word(32'h40), 32'h44}) begin
      n_fail++;
      $display("FAIL jr_target_word got v=%b i=%h p4=%h exp 1/%h/44",
               if_id_valid, if_id_instr, if_id_pc4, mem_word(32'h40));
    end
  endtask

  task automatic test_jump_drain();
    do_reset();
    mem_wait = 3; rst = 1'b0;
    ov_en = 1; ov_addr = 32'h0; ov_data = 32'h0800_0100;
    for (int i = 0; i < 4; i++) begin mem_tick(); next(); end
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc4, pc} !== {1'b1, 32'h0800_0100, 32'h4, 32'h4}) begin
      n_fail++;
      $display("FAIL jump_setup got v=%b i=%h p4=%h pc=%h exp 1/08000100/4/4",
               if_id_valid, if_id_instr, if_id_pc4, pc);
    end
    PCsrc = 2'b11;
    for (int i = 0; i < 3; i++) begin
      mem_tick(); next();
      n_checks++;
      if ({dbg_state, imem_req, imem_addr, if_id_valid} !== {S_DRAIN, 1'b1, 32'h4, 1'b0}) begin
        n_fail++;
        $display("FAIL drain_hold_%0d got st=%0d req=%b addr=%h v=%b exp DRAIN/1/4/0",
                 i, dbg_state, imem_req, imem_addr, if_id_valid);
      end
    end
    mem_tick(); next();
    n_checks++;
    if ({dbg_state, pc, if_id_valid} !== {S_FETCH, 32'h400, 1'b0}) begin
      n_fail++;
      $display("FAIL drain_exit got st=%0d pc=%h v=%b exp FETCH/400/0", dbg_state, pc, if_id_valid);
    end
    PCsrc = 2'b00;
    for (int i = 0; i < 4; i++) begin
      mem_tick(); next();
      n_checks++;
      if (if_id_valid !== (i == 3)) begin
        n_fail++;
        $display("FAIL jump_refill_%0d got v=%b exp %b", i, if_id_valid, (i == 3));
      end
    end
    n_checks++;
    if ({if_id_instr, if_id_pc4} !== {mem_word(32'h400), 32'h404}) begin
      n_fail++;
      $display("FAIL jump_word got i=%h p4=%h exp %h/404", if_id_instr, if_id_pc4, mem_word(32'h400));
    end
  endtask

  task automatic test_stall_held();
    logic [31:0] w0;
    do_reset();
    mem_wait = 0; rst = 1'b0;
    ov_en = 1; ov_addr = 32'h4; ov_data = 32'h2002_0005;
    w0 = mem_word(32'h0);
    mem_tick(); next();
    mem_tick(); stall = 1'b1; next();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({imem_req, if_id_valid, if_id_instr, if_id_pc4, pc, dbg_state} !==
          {1'b0, 1'b1, w0, 32'h4, 32'h4, S_HELD}) begin
        n_fail++;
        $display("FAIL held_%0d got req=%b v=%b i=%h p4=%h pc=%h st=%0d exp 0/1/%h/4/4/HELD",
                 i, imem_req, if_id_valid, if_id_instr, if_id_pc4, pc, dbg_state, w0);
      end
      if (i < 3) begin mem_tick(); next(); end
    end
    stall = 1'b0;
    mem_tick(); next();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc4, pc, imem_req} !==
        {1'b1, 32'h2002_0005, 32'h8, 32'h8, 1'b1}) begin
      n_fail++;
      $display("FAIL held_release got v=%b i=%h p4=%h pc=%h req=%b exp 1/20020005/8/8/1",
               if_id_valid, if_id_instr, if_id_pc4, pc, imem_req);
    end
  endtask

  task automatic test_reset_mid_and_wrap();
    do_reset();
    mem_wait = 3; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin mem_tick(); next(); end
    PCsrc = 2'b01; jr_target = 32'h80;
    mem_tick(); next();
    n_checks++;
    if (dbg_state !== S_DRAIN) begin
      n_fail++;
      $display("FAIL mid_drain_entry got st=%0d exp DRAIN", dbg_state);
    end
    PCsrc = 2'b00; rst = 1'b1;
    mem_tick(); next();
    n_checks++;
    if ({pc, if_id_valid, if_id_instr, if_id_pc4, dbg_state, imem_req} !==
        {32'h0, 1'b0, 32'h0, 32'h0, S_FETCH, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_drain got pc=%h v=%b i=%h p4=%h st=%0d req=%b",
               pc, if_id_valid, if_id_instr, if_id_pc4, dbg_state, imem_req);
    end
    rst = 1'b0; mem_wait = 0;
    mem_tick(); next();
    mem_tick(); stall = 1'b1; next();
    n_checks++;
    if (dbg_state !== S_HELD) begin
      n_fail++;
      $display("FAIL mid_held_entry got st=%0d exp HELD", dbg_state);
    end
    rst = 1'b1;
    mem_tick(); next();
    n_checks++;
    if ({pc, if_id_valid, if_id_instr, if_id_pc4, dbg_state} !==
        {32'h0, 1'b0, 32'h0, 32'h0, S_FETCH}) begin
      n_fail++;
      $display("FAIL rst_mid_held got pc=%h v=%b i=%h p4=%h st=%0d",
               pc, if_id_valid, if_id_instr, if_id_pc4, dbg_state);
    end
    rst = 1'b0; stall = 1'b0;
    mem_tick(); next();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc4} !== {1'b1, mem_word(32'h0), 32'h4}) begin
      n_fail++;
      $display("FAIL post_rst_fetch got v=%b i=%h p4=%h exp 1/%h/4",
               if_id_valid, if_id_instr, if_id_pc4, mem_word(32'h0));
    end
    PCsrc = 2'b01; jr_target = 32'hFFFF_FFFC;
    mem_tick(); next();
    PCsrc = 2'b00;
    mem_tick(); next();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc4, pc} !==
        {1'b1, mem_word(32'hFFFF_FFFC), 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL pc_wrap got v=%b i=%h p4=%h pc=%h exp 1/%h/0/0",
               if_id_valid, if_id_instr, if_id_pc4, pc, mem_word(32'hFFFF_FFFC));
    end
    mem_tick(); next();
    n_checks++;
    if ({if_id_instr, if_id_pc4} !== {mem_word(32'h0), 32'h4}) begin
      n_fail++;
      $display("FAIL after_wrap got i=%h p4=%h exp %h/4", if_id_instr, if_id_pc4, mem_word(32'h0));
    end
  endtask

  // ID consumes IF/ID on each edge with valid && !stall; the next consumed
  // instruction must come from the previous one's successor or its redirect target.
  task automatic test_random();
    int          idle;
    logic [31:0] exp_addr, w, pc4e;
    do_reset();
    rst = 1'b0; mem_wait_rand = 1;
    exp_addr = 32'h0;
    idle = 0;
    for (int c = 0; c < 3000; c++) begin
      mem_tick();
      if (mem_cont) begin
        n_checks++;
        if (imem_addr !== req_addr) begin
          n_fail++;
          $display("FAIL rand_addr_stable cyc %0d got %h exp %h", c, imem_addr, req_addr);
        end
      end
      n_checks++;
      if (mem_drop !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_req_dropped cyc %0d got drop=%b exp 0", c, mem_drop);
      end
      stall         = ($urandom_range(0, 3) == 0);
      PCsrc         = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      jr_target     = 32'($urandom_range(0, 1023)) << 2;
      branch_target = 32'($urandom_range(0, 1023)) << 2;
      if (if_id_valid && !stall) begin
        w    = mem_word(exp_addr);
        pc4e = exp_addr + 32'd4;
        n_checks++;
        if ({if_id_instr, if_id_pc4} !== {w, pc4e}) begin
          n_fail++;
          $display("FAIL rand_consume cyc %0d got i=%h p4=%h exp i=%h p4=%h",
                   c, if_id_instr, if_id_pc4, w, pc4e);
        end
        case (PCsrc)
          2'b01:   exp_addr = jr_target;
          2'b10:   exp_addr = branch_target;
          2'b11:   exp_addr = {pc4e[31:28], w[25:0], 2'b00};
          default: exp_addr = pc4e;
        endcase
        idle = 0;
      end else begin
        if (!if_id_valid) begin
          n_checks++;
          if ({if_id_instr, if_id_pc4} !== 64'h0) begin
            n_fail++;
            $display("FAIL rand_bubble cyc %0d got i=%h p4=%h exp 0/0", c, if_id_instr, if_id_pc4);
          end
        end
        idle++;
        if (idle > 40) begin
          n_checks++;
          n_fail++;
          $display("FAIL rand_progress cyc %0d got %0d idle cycles exp <= 40", c, idle);
          break;
        end
      end
      next();
    end
    stall = 1'b0; PCsrc = 2'b00;
  endtask

  initial begin
    next();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_jr();
    test_jump_drain();
    test_stall_held();
    test_reset_mid_and_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
